quad_encoder_gen: RTL and testbench

- Quadrature (A/B) encoder emulator: the transmitting end of the rotary-encoder interface whose receiver is the safe's OSE decoder.
- Accepts single-cycle step requests with a direction and plays them out as Gray-coded A/B waveforms at a programmable edge rate.
- Queues requests as a signed net pending count.
- Used on-board to drive the decoder from push-buttons and in benches as the decoder stimulus source.

---
 rtl/sejf_pkg.sv | 27 ++
 rtl/quad_step_queue.sv | 57 +++++
 rtl/quad_encoder_gen.sv | 131 +++++++++++++
 tb/tb_quad_encoder_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sejf_pkg.sv
// Shared constants for the quadrature encoder emulator: FSM encoding,
// Gray phase table and direction codes.
package sejf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int TIMER_W = 8;

    // {a,b} per phase index, phase 0 in the low bits: 00, 10, 11, 01
    localparam logic [7:0] GRAY_TAB = {2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] gray_of(input logic [1:0] phase);
        logic [2:0] base;
        base = {phase, 1'b0};
        return GRAY_TAB[base +: 2];
    endfunction

    function automatic logic [1:0] phase_step(input logic [1:0] phase, input logic dir);
        return (dir == DIR_UP) ? phase + 2'd1 : phase - 2'd1;
    endfunction

endpackage

// File: rtl/quad_step_queue.sv
// Saturating signed net step counter. Dequeue moves the count one toward
// zero and is applied before the same-cycle enqueue; drops set sticky ovf.
module quad_step_queue
    import sejf_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq,
    input  logic                enq_dir,
    input  logic                deq,
    output logic signed [W-1:0] count,
    output logic signed [W-1:0] count_nxt,
    output logic                head_dir,
    output logic                ovf
);

    localparam logic signed [W-1:0] CNT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] CNT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic signed [W-1:0] after_deq;
    logic                drop;

    always_comb begin
        after_deq = count;
        if (deq && (count != '0)) begin
            after_deq = count[W-1] ? (count + ONE) : (count - ONE);
        end

        drop      = 1'b0;
        count_nxt = after_deq;
        if (enq) begin
            if (enq_dir == DIR_UP) begin
                if (after_deq == CNT_MAX) drop = 1'b1;
                else                      count_nxt = after_deq + ONE;
            end else begin
                if (after_deq == CNT_MIN) drop = 1'b1;
                else                      count_nxt = after_deq - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (drop) ovf <= 1'b1;
        end
    end

    assign head_dir = count[W-1] ? DIR_DN : DIR_UP;

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B encoder emulator: plays queued steps out as Gray-coded
// edges spaced DWELL cycles apart, with GAP idle cycles after each step.
//
// state | meaning
// IDLE  | no step in progress; starts one when enabled and pending != 0
// RUN   | emitting the edges of one step in the latched direction
// GAP   | quiet time after a completed step
module quad_encoder_gen
    import sejf_pkg::*;
#(
    parameter int DWELL          = 4,
    parameter int EDGES_PER_STEP = 4,
    parameter int GAP            = 8,
    parameter int PEND_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     step_req,
    input  logic                     step_dir,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic signed [PEND_W-1:0] pending,
    output logic                     ovf
);

    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = (GAP > 0) ? TIMER_W'(GAP - 1) : '0;
    localparam logic [2:0]         EDGE_LOAD  = 3'(EDGES_PER_STEP);

    logic [1:0]         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [2:0]         edge_cnt, edge_nxt;
    logic [1:0]         phase, phase_nxt;
    logic               dir, dir_nxt;
    logic               deq;
    logic               head_dir;
    logic [1:0]         ab_nxt;
    logic               busy_nxt;

    logic signed [PEND_W-1:0] pending_nxt;

    quad_step_queue #(
        .W(PEND_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (step_req),
        .enq_dir  (step_dir),
        .deq      (deq),
        .count    (pending),
        .count_nxt(pending_nxt),
        .head_dir (head_dir),
        .ovf      (ovf)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        edge_nxt  = edge_cnt;
        phase_nxt = phase;
        dir_nxt   = dir;
        deq       = 1'b0;

        // With enable low everything holds; only the queue keeps accepting.
        if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (pending != '0) begin
                        deq       = 1'b1;
                        dir_nxt   = head_dir;
                        timer_nxt = DWELL_LOAD;
                        edge_nxt  = EDGE_LOAD;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (timer == '0) begin
                        phase_nxt = phase_step(phase, dir);
                        edge_nxt  = edge_cnt - 3'd1;
                        if (edge_cnt == 3'd1) begin
                            if (GAP > 0) begin
                                state_nxt = ST_GAP;
                                timer_nxt = GAP_LOAD;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            timer_nxt = DWELL_LOAD;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer == '0) state_nxt = ST_IDLE;
                    else             timer_nxt = timer - 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the FSM.
    assign ab_nxt   = gray_of(phase_nxt);
    assign busy_nxt = (state_nxt != ST_IDLE) || (pending_nxt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            phase    <= 2'd0;
            dir      <= DIR_UP;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            edge_cnt <= edge_nxt;
            phase    <= phase_nxt;
            dir      <= dir_nxt;
            a        <= ab_nxt[1];
            b        <= ab_nxt[0];
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: step-timeline reference model,
// edge-counting decoder, directed scenarios and randomized traffic.
module tb_quad_encoder_gen;

    localparam int DWELL  = 4;
    localparam int EDGES  = 4;
    localparam int GAP    = 8;
    localparam int PEND_W = 4;
    localparam int PMAX   = 7;
    localparam int PMIN   = -8;
    localparam int STEP_CYCLES = DWELL * EDGES + GAP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic step_req = 1'b0;
    logic step_dir = 1'b0;
    logic a, b, busy, ovf;
    logic signed [PEND_W-1:0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_encoder_gen #(
        .DWELL(DWELL), .EDGES_PER_STEP(EDGES), .GAP(GAP), .PEND_W(PEND_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .step_req(step_req), .step_dir(step_dir),
        .a(a), .b(b), .busy(busy), .pending(pending), .ovf(ovf)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] gray(input int pos);
        int m;
        m = ((pos % 4) + 4) % 4;
        case (m)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int idx(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    // Reference model: a step is a timeline of STEP_CYCLES enabled cycles,
    // with an edge at every DWELL-th cycle up to the EDGES-th.
    int m_pend = 0, m_t = 0, m_pos = 0;
    bit m_act = 0, m_dir = 0, m_ovf = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend <= 0; m_t <= 0; m_pos <= 0;
            m_act <= 0; m_dir <= 0; m_ovf <= 0;
        end else begin : mdl
            int p, t, pos;
            bit act, d, o;
            p = m_pend; t = m_t; pos = m_pos; act = m_act; d = m_dir; o = m_ovf;
            if (enable) begin
                if (!act) begin
                    if (p != 0) begin
                        act = 1; d = (p > 0); t = 0;
                        p = d ? p - 1 : p + 1;
                    end
                end else begin
                    t = t + 1;
                    if ((t % DWELL) == 0 && t <= DWELL * EDGES) pos = pos + (d ? 1 : -1);
                    if (t == STEP_CYCLES) act = 0;
                end
            end
            if (step_req) begin
                if (step_dir) begin
                    if (p == PMAX) o = 1; else p = p + 1;
                end else begin
                    if (p == PMIN) o = 1; else p = p - 1;
                end
            end
            m_pend <= p; m_t <= t; m_pos <= pos; m_act <= act; m_dir <= d; m_ovf <= o;
        end
    end

    // Per-cycle compare plus a decoder that counts net Gray edges.
    logic [1:0] prev_ab = 2'b00;
    int net_edges = 0;

    always @(negedge clk) begin : cmp
        logic [1:0] cur;
        int di, ham;
        cur = {a, b};
        if (rst) begin
            check("ab", cur, gray(m_pos));
            check("busy", busy, (m_act || m_pend != 0));
            check("pending", $signed(pending), m_pend);
            check("ovf", ovf, m_ovf);
            ham = $countones(cur ^ prev_ab);
            check("one_bit_change", (ham > 1), 0);
            di = (idx(cur) - idx(prev_ab) + 4) % 4;
            if (di == 1) net_edges++;
            else if (di == 3) net_edges--;
        end
        prev_ab = rst ? cur : 2'b00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input bit d);
        step_req = 1'b1;
        step_dir = d;
        tick(1);
        step_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e0;
        int rate;
        logic [1:0] seq_up [4];
        logic [1:0] seq_dn [4];
        seq_up[0] = 2'b10; seq_up[1] = 2'b11; seq_up[2] = 2'b01; seq_up[3] = 2'b00;
        seq_dn[0] = 2'b01; seq_dn[1] = 2'b11; seq_dn[2] = 2'b10; seq_dn[3] = 2'b00;

        tick(3);
        rst = 1'b1;
        enable = 1'b1;
        tick(100);
        check("idle_ab", {a, b}, 2'b00);
        check("idle_busy", busy, 0);
        check("idle_pending", $signed(pending), 0);
        check("idle_ovf", ovf, 0);

        // single up step then single down step, with literal timing
        for (int s = 0; s < 2; s++) begin
            e0 = net_edges;
            req(s == 0);
            check("step_pend_n1", $signed(pending), 1 - 2 * s);
            tick(1);
            check("step_pend_n2", $signed(pending), 0);
            check("step_busy_n2", busy, 1);
            tick(3);
            check("step_no_early_edge", {a, b}, 2'b00);
            for (int k = 0; k < 4; k++) begin
                tick(k == 0 ? 1 : 4);
                check("step_edge", {a, b}, (s == 0) ? seq_up[k] : seq_dn[k]);
            end
            tick(7);
            check("step_busy_n25", busy, 1);
            tick(1);
            check("step_busy_n26", busy, 0);
            check("step_detent", net_edges - e0, (s == 0) ? 4 : -4);
        end

        // queue and cancel: 3 up then 1 down
        e0 = net_edges;
        req(1); check("qc_pend1", $signed(pending), 1);
        req(1); check("qc_pend2", $signed(pending), 1);
        req(1); check("qc_pend3", $signed(pending), 2);
        req(0); check("qc_pend4", $signed(pending), 1);
        wait_idle(4 * STEP_CYCLES, "qc_drain");
        check("qc_edges", net_edges - e0, 8);

        // saturation while frozen
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req(1);
            if (i == 6) begin
                check("sat_pend7", $signed(pending), 7);
                check("sat_ovf_before", ovf, 0);
            end
            if (i >= 7) begin
                check("sat_pend_hold", $signed(pending), 7);
                check("sat_ovf", ovf, 1);
            end
        end
        check("sat_busy_frozen", busy, 1);
        e0 = net_edges;
        enable = 1'b1;
        wait_idle(8 * STEP_CYCLES, "sat_drain");
        check("sat_edges", net_edges - e0, 28);
        check("sat_ovf_sticky", ovf, 1);

        // freeze mid-RUN
        e0 = net_edges;
        req(1);
        tick(7);
        check("frz_first_edge", {a, b}, 2'b10);
        enable = 1'b0;
        tick(4);
        check("frz_held", {a, b}, 2'b10);
        tick(6);
        enable = 1'b1;
        tick(1);
        check("frz_resume_wait", {a, b}, 2'b10);
        tick(1);
        check("frz_resume_edge", {a, b}, 2'b11);
        wait_idle(2 * STEP_CYCLES, "frz_drain");
        check("frz_edges", net_edges - e0, 4);

        // asynchronous reset mid-step with a queued request
        req(1);
        req(1);
        check("ar_pend_queued", $signed(pending), 1);
        tick(10);
        check("ar_mid_ab", {a, b}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("ar_ab", {a, b}, 2'b00);
        check("ar_pending", $signed(pending), 0);
        check("ar_busy", busy, 0);
        check("ar_ovf", ovf, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // randomized traffic with enable toggling
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 20 : 4;
            step_req = ($urandom_range(0, rate - 1) == 0);
            step_dir = $urandom_range(0, 1);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick(1);
        end
        step_req = 1'b0;
        enable = 1'b1;
        wait_idle(10 * STEP_CYCLES, "rand_drain");
        check("rand_pend_zero", $signed(pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
